uart_tx_buffered: RTL

Buffered 8N1 UART transmitter: the transmit-side counterpart of the board's UART receiver, driving the Nexys4DDR USB-UART TXD pin. Host logic pushes bytes into an internal FIFO, and the block serialises them LSB-first at a fixed baud rate. A one-cycle DONE pulse marks each completed frame. It pairs with the receiver for echo and loopback designs and feeds the receiver directly in simulation.

---
 rtl/uart_tx_buffered.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter with byte FIFO
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLK100MHZ,
    input  logic       RESET_N,
    input  logic       TXEN,
    input  logic       WR,
    input  logic [7:0] DATA,
    output logic       FULL,
    output logic       EMPTY,
    output logic       BUSY,
    output logic       TXD,
    output logic       DONE
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA_BITS, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic             txd_next;
    logic             pop;
    logic             wr_ok;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;

    assign FULL  = (count == DEPTH_C);
    assign EMPTY = (count == '0);
    assign BUSY  = (state != IDLE);
    assign wr_ok = WR && !FULL;

    always_ff @(posedge CLK100MHZ) begin
        if (wr_ok) begin
            mem[wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            TXD   <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shift <= shift_next;
            TXD   <= txd_next;
        end
    end

    // TXD is registered from the next state so the line moves on the same edge as the FSM.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        pop        = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (TXEN && !EMPTY) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == LAST_CNT) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = DATA_BITS;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA_BITS: begin
                if (cnt == LAST_CNT) begin
                    cnt_next   = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    DONE       = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:     txd_next = 1'b0;
            DATA_BITS: txd_next = shift_next[0];
            default:   txd_next = 1'b1;
        endcase
    end
endmodule
